lamp_conflict_monitor: RTL and testbench
========================================

# lamp_conflict_monitor

Downstream stage of the intersection controller FSM. Registers the 2-bit light codes L_A/L_B, decodes them into one-hot lamp drives and checks every cycle for unsafe conditions: invalid code, both directions non-red, or an illegal per-direction transition. Any violation latches a fault and forces both heads into flashing red until software clears it. Unsafe values never reach the lamp outputs.

## Interface
- STARTUP_CYCLES, 8: cycles of solid all-red after reset or fault clear before lamps follow inputs (>=1)
- FLASH_HALF, 4: cycles per half-period of the fault flash (>=1)
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- L_A  input  2  light code direction A from controller (00 green, 01 yellow, 11 red, 10 invalid)
- L_B  input  2  light code direction B, same encoding
- clear_fault  input  1  request to leave fault flash; level, sampled each clk
- lamp_a  output  3  one-hot {red,yellow,green} drive, direction A
- lamp_b  output  3  one-hot {red,yellow,green} drive, direction B
- fault  output  1  latched fault flag
- fault_code  output  2  00 none, 01 invalid code, 10 conflict, 11 illegal transition

## Operation
- Input stage: la_q/lb_q <= L_A/L_B every clk; la_p/lb_p <= la_q/lb_q (previous). All four reset to red (11).
- Checks on la_q/lb_q, evaluated only in NORMAL, priority high to low:
  - invalid: either code == 10 -> 01
  - conflict: la_q != red and lb_q != red -> 10
  - illegal transition, per direction, prev -> cur: allowed are hold, green->yellow, yellow->red, red->green; all else (green->red, yellow->green, red->yellow) -> 11
- States:
  - STARTUP: lamps both 100; checks disabled; counter counts 0..STARTUP_CYCLES-1, then -> NORMAL.
  - NORMAL: lamps = decode(la_q/lb_q). Any violation -> FLASH, fault<=1, fault_code<=highest-priority code; lamps go to flash pattern on the same edge, decode not applied.
  - FLASH: lamp_a = lamp_b = {phase,0,0}; phase starts 1 on entry, toggles every FLASH_HALF cycles. fault and fault_code hold. clear_fault=1 while la_q and lb_q are both red -> STARTUP (counter restarts from 0), fault<=0, fault_code<=00. clear_fault with non-red inputs is ignored.
- clear_fault ignored in STARTUP and NORMAL.
- Several violations in one cycle: only the highest-priority code is latched.
- Violations in the final STARTUP cycle are not checked. Checking starts in the first NORMAL cycle, and the transition check there uses la_p/lb_p.

## Timing
- Reset values: lamp_a = lamp_b = 100, fault = 0, fault_code = 00, state STARTUP, counters 0, phase 1.
- reset_n low at any time, including mid-FLASH: immediate async return to reset values.
- Latency L_A -> lamp_a: 2 clk edges (input register, then lamp register).
- Violation on L_A at edge k: captured in la_q at edge k. At edge k+1: fault = 1, state FLASH, lamps 100. The bad code never drives a lamp.
- After reset deassert: the state leaves STARTUP at edge STARTUP_CYCLES and lamps follow inputs from edge STARTUP_CYCLES+1.
- Flash: lamp red bit is on for FLASH_HALF cycles, then off for FLASH_HALF cycles, repeating. Period = 2*FLASH_HALF.
- Clear: clear_fault sampled at edge j with legal all-red inputs gives fault = 0 and lamps solid 100 from edge j, then STARTUP_CYCLES of red.

## Structure
- Shared package traffic_pkg holds:
  - light codes LT_GREEN/LT_YELLOW/LT_RED/LT_INVALID
  - one-hot lamp constants
  - fault codes
  - state encoding for STARTUP/NORMAL/FLASH
- Sub-module lamp_transition_check (combinational, prev/cur code in, illegal flag out), instantiated once per direction.
- Top level holds the input/previous registers, priority encoder, FSM, startup and flash counters, and lamp registers.

## Test plan
- Reset, legal inputs A=00, B=11 -> lamps 100/100 for 8 cycles, then lamp_a = 001, lamp_b = 100; fault stays 0.
- Full legal cycle A 00->01->11 with B 11->00->01->11 -> lamps track with 2-cycle latency; no fault.
- In NORMAL, drive A=01, B=01 -> next edge fault = 1, fault_code = 10; lamps show 100 for 4 cycles, 000 for 4, repeating; 010/010 never appears.
- A 00 -> 11 directly (B red) -> fault_code = 11. Separately, A = 10 together with B = 00 -> fault_code = 01 (invalid outranks conflict).
- In FLASH, clear_fault with A=00 -> ignored. Then clear_fault with A=B=11 -> fault = 0, code 00, 8 red cycles, then resume NORMAL.
- reset_n pulsed low mid-FLASH -> outputs immediately 100/100, fault = 0; STARTUP repeats.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the intersection lamp path: the 2-bit light codes
// produced by the controller FSM, the one-hot lamp drive patterns, the
// latched fault codes and the monitor's state encoding.
// No ports (package).

package traffic_pkg;

    // Light codes from the intersection controller
    localparam logic [1:0] LT_GREEN   = 2'b00;
    localparam logic [1:0] LT_YELLOW  = 2'b01;
    localparam logic [1:0] LT_RED     = 2'b11;
    localparam logic [1:0] LT_INVALID = 2'b10;

    // One-hot lamp drives, bit order {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    // Latched fault codes
    localparam logic [1:0] FC_NONE       = 2'b00;
    localparam logic [1:0] FC_INVALID    = 2'b01;
    localparam logic [1:0] FC_CONFLICT   = 2'b10;
    localparam logic [1:0] FC_TRANSITION = 2'b11;

    // Monitor state encoding
    localparam logic [1:0] ST_STARTUP = 2'b00;
    localparam logic [1:0] ST_NORMAL  = 2'b01;
    localparam logic [1:0] ST_FLASH   = 2'b10;

    // Light code to lamp drive. The invalid code maps to red so that a
    // decode of a bad value can never light anything permissive.
    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        logic [2:0] lamp;
        case (code)
            LT_GREEN:  lamp = LAMP_GREEN;
            LT_YELLOW: lamp = LAMP_YELLOW;
            default:   lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/lamp_transition_check.sv
// lamp_transition_check
// Combinational legality check of one direction's light sequence.
// Allowed moves: hold, green->yellow, yellow->red, red->green.
// Anything else (including any move into or out of the invalid code) is
// flagged as illegal.
// Ports:
//   prev_code  in   2  code registered one cycle earlier
//   cur_code   in   2  current registered code
//   illegal    out  1  high when prev_code -> cur_code is not an allowed move

module lamp_transition_check
    import traffic_pkg::*;
(
    input  logic [1:0] prev_code,
    input  logic [1:0] cur_code,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b1;
        if (cur_code == prev_code) begin
            illegal = 1'b0;
        end else if (prev_code == LT_GREEN && cur_code == LT_YELLOW) begin
            illegal = 1'b0;
        end else if (prev_code == LT_YELLOW && cur_code == LT_RED) begin
            illegal = 1'b0;
        end else if (prev_code == LT_RED && cur_code == LT_GREEN) begin
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor
// Safety stage behind the intersection controller. Registers the two light
// codes, decodes them into one-hot lamp drives and, while in NORMAL, checks
// every cycle for an invalid code, both directions non-red, or an illegal
// per-direction transition. A violation latches a fault and puts both heads
// into flashing red until clear_fault is seen with both inputs red. A
// violating code is only ever seen in the input registers; the lamp
// registers load the flash pattern instead of its decode.
// Ports:
//   clk          in   1  clock
//   reset_n      in   1  asynchronous active-low reset
//   L_A, L_B     in   2  light codes (00 green, 01 yellow, 11 red, 10 invalid)
//   clear_fault  in   1  level request to leave fault flash
//   lamp_a/b     out  3  one-hot {red,yellow,green} drives
//   fault        out  1  latched fault flag
//   fault_code   out  2  00 none, 01 invalid, 10 conflict, 11 transition

module lamp_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int STARTUP_CYCLES = 8,
    parameter int FLASH_HALF     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] L_A,
    input  logic [1:0] L_B,
    input  logic       clear_fault,
    output logic [2:0] lamp_a,
    output logic [2:0] lamp_b,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);

    // Index 0 is direction A, index 1 is direction B
    logic [1:0][1:0] code_in;
    logic [1:0][1:0] code_q_reg;
    logic [1:0][1:0] code_p_reg;
    logic [1:0]      illegal;

    logic [1:0]      state_reg, state_next;
    logic [SU_W-1:0] su_cnt_reg, su_cnt_next;
    logic [FL_W-1:0] fl_cnt_reg, fl_cnt_next;
    logic            phase_reg, phase_next;
    logic [2:0]      lamp_a_reg, lamp_a_next;
    logic [2:0]      lamp_b_reg, lamp_b_next;
    logic            fault_reg, fault_next;
    logic [1:0]      fault_code_reg, fault_code_next;

    logic            any_invalid;
    logic            conflict;
    logic            both_red;
    logic [1:0]      violation_code;

    assign code_in[0] = L_A;
    assign code_in[1] = L_B;

    // Input and previous-value registers, both directions. Everything
    // resets to red so the first NORMAL transition check sees a sane history.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    code_q_reg[gi] <= LT_RED;
                    code_p_reg[gi] <= LT_RED;
                end else begin
                    code_q_reg[gi] <= code_in[gi];
                    code_p_reg[gi] <= code_q_reg[gi];
                end
            end

            lamp_transition_check u_transition_check (
                .prev_code (code_p_reg[gi]),
                .cur_code  (code_q_reg[gi]),
                .illegal   (illegal[gi])
            );
        end
    endgenerate

    assign any_invalid = (code_q_reg[0] == LT_INVALID) || (code_q_reg[1] == LT_INVALID);
    assign conflict    = (code_q_reg[0] != LT_RED) && (code_q_reg[1] != LT_RED);
    assign both_red    = (code_q_reg[0] == LT_RED) && (code_q_reg[1] == LT_RED);

    // Priority encoder: invalid > conflict > illegal transition
    always_comb begin
        violation_code = FC_NONE;
        if (any_invalid) begin
            violation_code = FC_INVALID;
        end else if (conflict) begin
            violation_code = FC_CONFLICT;
        end else if (|illegal) begin
            violation_code = FC_TRANSITION;
        end
    end

    always_comb begin
        state_next      = state_reg;
        su_cnt_next     = su_cnt_reg;
        fl_cnt_next     = fl_cnt_reg;
        phase_next      = phase_reg;
        lamp_a_next     = lamp_a_reg;
        lamp_b_next     = lamp_b_reg;
        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;

        case (state_reg)
            ST_STARTUP: begin
                lamp_a_next = LAMP_RED;
                lamp_b_next = LAMP_RED;
                if (su_cnt_reg == SU_LAST) begin
                    state_next  = ST_NORMAL;
                    su_cnt_next = '0;
                end else begin
                    su_cnt_next = su_cnt_reg + SU_W'(1);
                end
            end

            ST_NORMAL: begin
                if (violation_code != FC_NONE) begin
                    // Flash starts in the red half; the offending code is
                    // never decoded onto the lamps.
                    state_next      = ST_FLASH;
                    fault_next      = 1'b1;
                    fault_code_next = violation_code;
                    phase_next      = 1'b1;
                    fl_cnt_next     = '0;
                    lamp_a_next     = LAMP_RED;
                    lamp_b_next     = LAMP_RED;
                end else begin
                    lamp_a_next = decode_lamp(code_q_reg[0]);
                    lamp_b_next = decode_lamp(code_q_reg[1]);
                end
            end

            ST_FLASH: begin
                if (clear_fault && both_red) begin
                    state_next      = ST_STARTUP;
                    su_cnt_next     = '0;
                    fault_next      = 1'b0;
                    fault_code_next = FC_NONE;
                    phase_next      = 1'b1;
                    fl_cnt_next     = '0;
                    lamp_a_next     = LAMP_RED;
                    lamp_b_next     = LAMP_RED;
                end else if (fl_cnt_reg == FL_LAST) begin
                    fl_cnt_next = '0;
                    phase_next  = ~phase_reg;
                    lamp_a_next = {~phase_reg, 2'b00};
                    lamp_b_next = {~phase_reg, 2'b00};
                end else begin
                    fl_cnt_next = fl_cnt_reg + FL_W'(1);
                    lamp_a_next = {phase_reg, 2'b00};
                    lamp_b_next = {phase_reg, 2'b00};
                end
            end

            default: begin
                // Unreachable encoding: fall back to a safe restart
                state_next  = ST_STARTUP;
                su_cnt_next = '0;
                lamp_a_next = LAMP_RED;
                lamp_b_next = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_STARTUP;
            su_cnt_reg     <= '0;
            fl_cnt_reg     <= '0;
            phase_reg      <= 1'b1;
            lamp_a_reg     <= LAMP_RED;
            lamp_b_reg     <= LAMP_RED;
            fault_reg      <= 1'b0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg      <= state_next;
            su_cnt_reg     <= su_cnt_next;
            fl_cnt_reg     <= fl_cnt_next;
            phase_reg      <= phase_next;
            lamp_a_reg     <= lamp_a_next;
            lamp_b_reg     <= lamp_b_next;
            fault_reg      <= fault_next;
            fault_code_reg <= fault_code_next;
        end
    end

    assign lamp_a     = lamp_a_reg;
    assign lamp_b     = lamp_b_reg;
    assign fault      = fault_reg;
    assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// tb_lamp_conflict_monitor
// Table-driven bench for lamp_conflict_monitor. Each table row is the input
// applied for one clock plus the outputs expected just after that edge.

module tb_lamp_conflict_monitor;

    localparam logic [1:0] G   = 2'b00;
    localparam logic [1:0] Y   = 2'b01;
    localparam logic [1:0] R   = 2'b11;
    localparam logic [1:0] INV = 2'b10;

    localparam logic [2:0] LR  = 3'b100;
    localparam logic [2:0] LY  = 3'b010;
    localparam logic [2:0] LG  = 3'b001;
    localparam logic [2:0] LO  = 3'b000;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_INV   = 2'b01;
    localparam logic [1:0] C_CONF  = 2'b10;
    localparam logic [1:0] C_TRANS = 2'b11;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       clr;
        logic [2:0] ea;
        logic [2:0] eb;
        logic       ef;
        logic [1:0] ec;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] L_A;
    logic [1:0] L_B;
    logic       clear_fault;
    logic [2:0] lamp_a;
    logic [2:0] lamp_b;
    logic       fault;
    logic [1:0] fault_code;

    int tests_run = 0;
    int tests_failed = 0;

    vec_t vecs[$];

    lamp_conflict_monitor #(
        .STARTUP_CYCLES (8),
        .FLASH_HALF     (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .L_A         (L_A),
        .L_B         (L_B),
        .clear_fault (clear_fault),
        .lamp_a      (lamp_a),
        .lamp_b      (lamp_b),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [1:0] a, input logic [1:0] b, input logic clr,
                                input logic [2:0] ea, input logic [2:0] eb,
                                input logic ef, input logic [1:0] ec);
        vec_t v;
        v.a = a; v.b = b; v.clr = clr;
        v.ea = ea; v.eb = eb; v.ef = ef; v.ec = ec;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got lamp_a=%b lamp_b=%b fault=%b code=%b, expected lamp_a=%b lamp_b=%b fault=%b code=%b",
                     name, got[8:6], got[5:3], got[2], got[1:0], exp[8:6], exp[5:3], exp[2], exp[1:0]);
        end
    endtask

    // Called at a negative edge: drive, take the rising edge, sample 1 ns later
    task automatic step(input string name, input vec_t v);
        L_A = v.a;
        L_B = v.b;
        clear_fault = v.clr;
        @(posedge clk);
        #1;
        check(name, {lamp_a, lamp_b, fault, fault_code}, {v.ea, v.eb, v.ef, v.ec});
        $display("[TB] %s A=%b B=%b clr=%b -> lamp_a=%b lamp_b=%b fault=%b code=%b",
                 name, v.a, v.b, v.clr, lamp_a, lamp_b, fault, fault_code);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // ---- main table (row n is applied before edge n after reset release) ----
        // STARTUP: 8 red cycles; clear_fault pulse on row 3 must not restart it
        for (int i = 1; i <= 8; i++) add(G, R, (i == 3), LR, LR, 1'b0, C_NONE);
        add(G, R, 1'b0, LG, LR, 1'b0, C_NONE);              // 9: lamps follow
        add(Y, R, 1'b0, LG, LR, 1'b0, C_NONE);              // 10
        add(R, R, 1'b0, LY, LR, 1'b0, C_NONE);              // 11
        add(R, G, 1'b1, LR, LR, 1'b0, C_NONE);              // 12: clear ignored in NORMAL
        add(R, Y, 1'b0, LR, LG, 1'b0, C_NONE);              // 13
        add(R, R, 1'b0, LR, LY, 1'b0, C_NONE);              // 14
        add(R, R, 1'b0, LR, LR, 1'b0, C_NONE);              // 15
        add(Y, Y, 1'b0, LR, LR, 1'b0, C_NONE);              // 16: conflict enters la_q
        for (int i = 17; i <= 20; i++) add(Y, Y, 1'b0, LR, LR, 1'b1, C_CONF);
        for (int i = 21; i <= 24; i++) add(Y, Y, 1'b0, LO, LO, 1'b1, C_CONF);
        add(Y, Y, 1'b0, LR, LR, 1'b1, C_CONF);              // 25: red half again
        add(G, R, 1'b0, LR, LR, 1'b1, C_CONF);              // 26
        add(G, R, 1'b1, LR, LR, 1'b1, C_CONF);              // 27: clear with A green ignored
        add(R, R, 1'b1, LR, LR, 1'b1, C_CONF);              // 28: la_q still green, ignored
        add(R, R, 1'b1, LR, LR, 1'b0, C_NONE);              // 29: clear accepted
        for (int i = 30; i <= 37; i++) add(G, R, 1'b0, LR, LR, 1'b0, C_NONE);
        add(G, R, 1'b0, LG, LR, 1'b0, C_NONE);              // 38: NORMAL resumes
        add(R, R, 1'b0, LG, LR, 1'b0, C_NONE);              // 39: green->red enters la_q
        add(R, R, 1'b0, LR, LR, 1'b1, C_TRANS);             // 40
        add(R, R, 1'b1, LR, LR, 1'b0, C_NONE);              // 41: clear
        for (int i = 42; i <= 49; i++) add(G, R, 1'b0, LR, LR, 1'b0, C_NONE);
        add(G, R, 1'b0, LG, LR, 1'b0, C_NONE);              // 50
        add(INV, G, 1'b0, LG, LR, 1'b0, C_NONE);            // 51: invalid + conflict + bad move
        add(INV, G, 1'b0, LR, LR, 1'b1, C_INV);             // 52: invalid wins
        add(INV, G, 1'b0, LR, LR, 1'b1, C_INV);             // 53

        // ---- reset state ----
        reset_n = 1'b0;
        L_A = G;
        L_B = R;
        clear_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {lamp_a, lamp_b, fault, fault_code}, {LR, LR, 1'b0, C_NONE});
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("row%0d", i + 1), vecs[i]);
        end

        // ---- asynchronous reset in the middle of FLASH ----
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_flash", {lamp_a, lamp_b, fault, fault_code}, {LR, LR, 1'b0, C_NONE});
        $display("[TB] async reset -> lamp_a=%b lamp_b=%b fault=%b code=%b",
                 lamp_a, lamp_b, fault, fault_code);
        @(negedge clk);
        reset_n = 1'b1;

        // STARTUP repeats; a conflict visible only in the final STARTUP
        // cycle (rows 7/8) must not raise a fault.
        for (int i = 1; i <= 10; i++) begin
            v.a   = (i == 7) ? Y : ((i >= 9) ? G : R);
            v.b   = (i == 7) ? Y : R;
            v.clr = 1'b0;
            v.ea  = (i == 10) ? LG : LR;
            v.eb  = LR;
            v.ef  = 1'b0;
            v.ec  = C_NONE;
            step($sformatf("post_reset%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
